// File: rtl/ant_relay_seq.sv
`default_nettype none
// ============================================================================
// Module   : ant_relay_seq
// Purpose  : Two-radio antenna relay sequencer. Each radio's selection is
//            debounced and applied break-before-make. Optional same-antenna
//            interlock is enabled by defining ANT_INTERLOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ant_relay_seq #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned DEAD_CYC     = 200
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [2:0] I_sel_A,
  input  logic [2:0] I_sel_B,
  output logic [5:0] O_relay_A,
  output logic [5:0] O_relay_B,
  output logic       O_busy,
  output logic       O_conflict_A,
  output logic       O_conflict_B
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_QUAL  = 2'd1,
    S_BREAK = 2'd2,
    S_MAKE  = 2'd3
  } state_t;

  localparam logic [15:0] QUAL_LAST = 16'(DEBOUNCE_CYC - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYC);

  state_t      state_q [2];
  state_t      state_d [2];
  logic [2:0]  tgt_q   [2];
  logic [2:0]  tgt_d   [2];
  logic [2:0]  smp_q   [2];
  logic [2:0]  smp_d   [2];
  logic [15:0] cnt_q   [2];
  logic [15:0] cnt_d   [2];
  logic [5:0]  relay_q [2];
  logic [5:0]  relay_d [2];
  logic [1:0]  conf_q;
  logic [1:0]  conf_d;
  logic        busy_q;
  logic        busy_d;

  logic [1:0][2:0] sel_norm;
  logic [1:0]      refuse;
  logic [1:0]      retry;

  function automatic logic [2:0] norm_sel(input logic [2:0] s);
    return (s == 3'd7) ? 3'd0 : s;
  endfunction

  function automatic logic [5:0] onehot(input logic [2:0] t);
    case (t)
      3'd1:    return 6'b000001;
      3'd2:    return 6'b000010;
      3'd3:    return 6'b000100;
      3'd4:    return 6'b001000;
      3'd5:    return 6'b010000;
      3'd6:    return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  assign sel_norm = {norm_sel(I_sel_B), norm_sel(I_sel_A)};

  // A only yields to a settled B; B also yields to an A making in the same cycle.
  always_comb begin
`ifdef ANT_INTERLOCK_EN
    refuse[0] = (state_q[1] == S_HOLD) &&
                (tgt_q[1] == tgt_q[0]) && (tgt_q[0] != 3'd0);
    refuse[1] = ((state_q[0] == S_HOLD) || (state_q[0] == S_MAKE)) &&
                (tgt_q[0] == tgt_q[1]) && (tgt_q[1] != 3'd0);
    retry[0]  = conf_q[0] && (tgt_q[1] != tgt_q[0]);
    retry[1]  = conf_q[1] && (tgt_q[0] != tgt_q[1]);
`else
    refuse = 2'b00;
    retry  = 2'b00;
`endif
  end

  always_comb begin
    busy_d = 1'b0;
    conf_d = conf_q;
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      tgt_d[ch]   = tgt_q[ch];
      smp_d[ch]   = smp_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      relay_d[ch] = relay_q[ch];
      case (state_q[ch])
        S_HOLD: begin
          if (sel_norm[ch] != tgt_q[ch]) begin
            state_d[ch] = S_QUAL;
            smp_d[ch]   = sel_norm[ch];
            cnt_d[ch]   = 16'd0;
          end else if (retry[ch]) begin
            state_d[ch] = S_BREAK;
            cnt_d[ch]   = 16'd0;
          end
        end
        S_QUAL: begin
          if (sel_norm[ch] == tgt_q[ch]) begin
            state_d[ch] = S_HOLD;
          end else if (sel_norm[ch] != smp_q[ch]) begin
            smp_d[ch] = sel_norm[ch];
            cnt_d[ch] = 16'd0;
          end else if (cnt_q[ch] == QUAL_LAST) begin
            state_d[ch] = S_BREAK;
            tgt_d[ch]   = sel_norm[ch];
            cnt_d[ch]   = 16'd0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 16'd1;
          end
        end
        S_BREAK: begin
          relay_d[ch] = 6'b000000;
          if (cnt_q[ch] == DEAD_LAST) begin
            state_d[ch] = S_MAKE;
            cnt_d[ch]   = 16'd0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 16'd1;
          end
        end
        S_MAKE: begin
          relay_d[ch] = refuse[ch] ? 6'b000000 : onehot(tgt_q[ch]);
          conf_d[ch]  = refuse[ch];
          state_d[ch] = S_HOLD;
        end
        default: state_d[ch] = S_HOLD;
      endcase
      // Busy drops on the same edge that lands the channel back in HOLD.
      busy_d = busy_d || ((state_q[ch] != S_HOLD) && (state_d[ch] != S_HOLD));
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= S_HOLD;
        tgt_q[ch]   <= 3'd0;
        smp_q[ch]   <= 3'd0;
        cnt_q[ch]   <= 16'd0;
        relay_q[ch] <= 6'b000000;
      end
      conf_q <= 2'b00;
      busy_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        tgt_q[ch]   <= tgt_d[ch];
        smp_q[ch]   <= smp_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        relay_q[ch] <= relay_d[ch];
      end
      conf_q <= conf_d;
      busy_q <= busy_d;
    end
  end

  assign O_relay_A    = relay_q[0];
  assign O_relay_B    = relay_q[1];
  assign O_busy       = busy_q;
  assign O_conflict_A = conf_q[0];
  assign O_conflict_B = conf_q[1];

endmodule
`default_nettype wire

// File: tb/tb_ant_relay_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ant_relay_seq
// Purpose  : Scoreboard bench for ant_relay_seq (DEBOUNCE_CYC=4, DEAD_CYC=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_ant_relay_seq;

`ifdef ANT_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  localparam int S_RA = 0;
  localparam int S_RB = 1;
  localparam int S_BUSY = 2;
  localparam int S_CA = 3;
  localparam int S_CB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sel_a;
  logic [2:0] sel_b;
  logic [5:0] relay_a;
  logic [5:0] relay_b;
  logic       busy;
  logic       conf_a;
  logic       conf_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;
  exp_t q[$];

  ant_relay_seq #(
    .DEBOUNCE_CYC(4),
    .DEAD_CYC    (8)
  ) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_sel_A     (sel_a),
    .I_sel_B     (sel_b),
    .O_relay_A   (relay_a),
    .O_relay_B   (relay_b),
    .O_busy      (busy),
    .O_conflict_A(conf_a),
    .O_conflict_B(conf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int s);
    case (s)
      S_RA:    return int'(relay_a);
      S_RB:    return int'(relay_b);
      S_BUSY:  return int'(busy);
      S_CA:    return int'(conf_a);
      default: return int'(conf_b);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_RA:    return "relay_A";
      S_RB:    return "relay_B";
      S_BUSY:  return "busy";
      S_CA:    return "conflict_A";
      default: return "conflict_B";
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    q.push_back(e);
  endtask

  // Edge index: n rising edges from now, then settle away from the edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compare every expectation due at this cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) check({"missed_", sig_name(e.sig)}, cyc, e.cyc);
      else check(sig_name(e.sig), actual(e.sig), e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sel_a = 3'd0;
    sel_b = 3'd0;
    #3;
    check("rst_relay_A", int'(relay_a), 0);
    check("rst_relay_B", int'(relay_b), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_conf_A", int'(conf_a), 0);
    check("rst_conf_B", int'(conf_b), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_edges(2);

    // A: 0 -> 3, full debounce + dead time
    sel_a = 3'd3; e0 = cyc + 1;
    push(e0, S_BUSY, 0);
    push(e0 + 1, S_BUSY, 1);
    push(e0 + 13, S_RA, 0);
    push(e0 + 13, S_BUSY, 1);
    push(e0 + 14, S_RA, 6'b000100);
    push(e0 + 14, S_BUSY, 0);
    wait_edges(16);

    // Glitch to 5 for two samples, then back to 3
    sel_a = 3'd5; e0 = cyc + 1;
    push(e0 + 1, S_RA, 6'b000100);
    push(e0 + 1, S_BUSY, 1);
    push(e0 + 2, S_RA, 6'b000100);
    push(e0 + 2, S_BUSY, 0);
    push(e0 + 10, S_RA, 6'b000100);
    wait_edges(2);
    sel_a = 3'd3;
    wait_edges(12);

    // A to 2, then B requests 2
    sel_a = 3'd2; e0 = cyc + 1;
    push(e0 + 13, S_RA, 0);
    push(e0 + 14, S_RA, 6'b000010);
    wait_edges(16);
    sel_b = 3'd2; e0 = cyc + 1;
    push(e0 + 13, S_RB, 0);
    push(e0 + 14, S_RA, 6'b000010);
    push(e0 + 14, S_RB, IL ? 0 : 6'b000010);
    push(e0 + 14, S_CB, IL ? 1 : 0);
    wait_edges(16);
    // A moves to 4; a refused B retries once A's target changes
    sel_a = 3'd4; e0 = cyc + 1;
    push(e0 + 13, S_RA, 0);
    push(e0 + 14, S_RA, 6'b001000);
    push(e0 + 14, S_RB, IL ? 0 : 6'b000010);
    push(e0 + 14, S_CB, IL ? 1 : 0);
    push(e0 + 15, S_RB, 6'b000010);
    push(e0 + 15, S_CB, 0);
    wait_edges(17);

    // Simultaneous request for antenna 6
    sel_a = 3'd6; sel_b = 3'd6; e0 = cyc + 1;
    push(e0 + 14, S_RA, 6'b100000);
    push(e0 + 14, S_RB, IL ? 0 : 6'b100000);
    push(e0 + 14, S_CA, 0);
    push(e0 + 14, S_CB, IL ? 1 : 0);
    wait_edges(16);

    // Reset pulse while A is in BREAK
    sel_a = 3'd3; e0 = cyc + 1;
    push(e0 + 4, S_BUSY, 1);
    wait_edges(6);
    #1 rst_n = 1'b0;
    sel_b = 3'd0;
    #1;
    check("arst_relay_A", int'(relay_a), 0);
    check("arst_relay_B", int'(relay_b), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_conf_A", int'(conf_a), 0);
    check("arst_conf_B", int'(conf_b), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0 + 13, S_RA, 0);
    push(e0 + 14, S_RA, 6'b000100);
    push(e0 + 14, S_RB, 0);
    push(e0 + 14, S_BUSY, 0);
    wait_edges(16);

    // A to 1, then input 7 means no antenna
    sel_a = 3'd1; e0 = cyc + 1;
    push(e0 + 14, S_RA, 6'b000001);
    wait_edges(16);
    sel_a = 3'd7; e0 = cyc + 1;
    push(e0 + 4, S_RA, 6'b000001);
    push(e0 + 5, S_RA, 0);
    push(e0 + 5, S_BUSY, 1);
    push(e0 + 14, S_RA, 0);
    push(e0 + 14, S_CA, 0);
    push(e0 + 14, S_BUSY, 0);
    wait_edges(16);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) check("drain_pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
